// File: rtl/pcs_rx_word_aligner_pkg.sv
// Shared constants, FSM encoding and helpers for the PCS receive word aligner.
package pcs_rx_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        CHECK     = 2'd1,
        LOCKED    = 2'd2
    } align_state_t;

    // Width of the bit-offset field for a word of sym_per_word 10-bit symbols.
    function automatic int off_width(input int sym_per_word);
        return $clog2(10 * sym_per_word);
    endfunction

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

endpackage

// File: rtl/pcs_rx_word_aligner_if.sv
// Receive-side bus between the bit collector / elastic buffer and the word aligner.
// Lock_Loss_Cnt is present only when ALIGN_LOSS_CNT_EN is defined.
interface pcs_rx_word_aligner_if #(
    parameter int SYM_PER_WORD = 2
);
    localparam int W  = 10 * SYM_PER_WORD;
    localparam int OW = pcs_rx_pkg::off_width(SYM_PER_WORD);

    logic [W-1:0]            Data_in;
    logic                    Data_in_Valid;
    logic [W-1:0]            Data_out;
    logic [SYM_PER_WORD-1:0] Comma_Det;
    logic                    RX_Valid;
    logic [OW-1:0]           Align_Offset;
    logic                    Lock_Lost;
`ifdef ALIGN_LOSS_CNT_EN
    logic [7:0]              Lock_Loss_Cnt;

    modport master (
        output Data_in, Data_in_Valid,
        input  Data_out, Comma_Det, RX_Valid, Align_Offset, Lock_Lost, Lock_Loss_Cnt
    );
    modport slave (
        input  Data_in, Data_in_Valid,
        output Data_out, Comma_Det, RX_Valid, Align_Offset, Lock_Lost, Lock_Loss_Cnt
    );
`else
    modport master (
        output Data_in, Data_in_Valid,
        input  Data_out, Comma_Det, RX_Valid, Align_Offset, Lock_Lost
    );
    modport slave (
        input  Data_in, Data_in_Valid,
        output Data_out, Comma_Det, RX_Valid, Align_Offset, Lock_Lost
    );
`endif
endinterface

// File: rtl/pcs_rx_word_aligner_comma_search.sv
// Combinational scan of every candidate bit offset for a K28.5 comma; the lowest hit wins.
module pcs_rx_word_aligner_comma_search
    import pcs_rx_pkg::*;
#(
    parameter int W  = 20,
    parameter int OW = 5
) (
    input  logic [W+8:0]  window,
    output logic          hit,
    output logic [OW-1:0] hit_q
);

    always_comb begin
        hit   = 1'b0;
        hit_q = '0;
        // Scan downwards so the final assignment is the lowest matching offset.
        for (int i = W - 1; i >= 0; i--) begin
            if (is_comma(window[i +: 10])) begin
                hit   = 1'b1;
                hit_q = OW'(i);
            end
        end
    end

endmodule

// File: rtl/pcs_rx_word_aligner.sv
// PCS receive word aligner: comma search, lock/unlock hysteresis and aligned word output.
// Optional lock-loss counter enabled by defining ALIGN_LOSS_CNT_EN.
module pcs_rx_word_aligner
    import pcs_rx_pkg::*;
#(
    parameter int SYM_PER_WORD = 2,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                  CLK,
    input  logic                  Rst,
    pcs_rx_word_aligner_if.slave  rx
);

    localparam int W  = 10 * SYM_PER_WORD;
    localparam int OW = off_width(SYM_PER_WORD);

    align_state_t            state, state_nxt;
    logic [OW-1:0]           off, off_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [3:0]              err, err_nxt;
    logic                    lost_nxt;

    logic [W-1:0]            prev_p0;
    logic [2*W-2:0]          window_p0;
    logic                    vld_p0;
    logic                    hit;
    logic [OW-1:0]           hit_q;
    logic                    aligned;
    logic [W-1:0]            word_p0;
    logic [SYM_PER_WORD-1:0] cdet_p0;

    logic [W-1:0]            data_p1;
    logic [SYM_PER_WORD-1:0] cdet_p1;
    logic                    rxv_p1;
    logic                    lost_p1;

    // Stage p0: window of current word over the previous valid word, comma scan
    assign vld_p0    = rx.Data_in_Valid;
    assign window_p0 = {rx.Data_in[W-2:0], prev_p0};

    pcs_rx_word_aligner_comma_search #(
        .W  (W),
        .OW (OW)
    ) u_comma_search (
        .window (window_p0[W+8:0]),
        .hit    (hit),
        .hit_q  (hit_q)
    );

    // A comma landing on any symbol lane boundary at or above the offset keeps alignment.
    always_comb begin
        aligned = 1'b0;
        for (int k = 0; k < SYM_PER_WORD; k++) begin
            if (int'(hit_q) == int'(off) + 10 * k) aligned = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        off_nxt   = off;
        cnt_nxt   = cnt;
        err_nxt   = err;
        lost_nxt  = 1'b0;
        if (vld_p0 && hit) begin
            case (state)
                UNALIGNED: begin
                    off_nxt   = hit_q;
                    cnt_nxt   = 4'd1;
                    state_nxt = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                end
                CHECK: begin
                    if (aligned) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt_nxt == 4'(LOCK_COUNT)) state_nxt = LOCKED;
                    end else begin
                        off_nxt = hit_q;
                        cnt_nxt = 4'd1;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        err_nxt = 4'd0;
                    end else if (err + 4'd1 == 4'(UNLOCK_COUNT)) begin
                        state_nxt = UNALIGNED;
                        err_nxt   = 4'd0;
                        lost_nxt  = 1'b1;
                    end else begin
                        err_nxt = err + 4'd1;
                    end
                end
                default: state_nxt = UNALIGNED;
            endcase
        end
    end

    // A freshly captured offset already steers the word being registered.
    assign word_p0 = window_p0[off_nxt +: W];

    always_comb begin
        cdet_p0 = '0;
        for (int i = 0; i < SYM_PER_WORD; i++) begin
            cdet_p0[i] = is_comma(word_p0[10*i +: 10]);
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state <= UNALIGNED;
            off   <= '0;
            cnt   <= 4'd0;
            err   <= 4'd0;
        end else if (vld_p0) begin
            state <= state_nxt;
            off   <= off_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // Stage p1: aligned output register, flags travel with the word
    always_ff @(posedge CLK) begin
        if (Rst) begin
            prev_p0 <= '0;
            data_p1 <= '0;
            cdet_p1 <= '0;
            rxv_p1  <= 1'b0;
            lost_p1 <= 1'b0;
        end else begin
            lost_p1 <= lost_nxt;
            if (vld_p0) begin
                prev_p0 <= rx.Data_in;
                data_p1 <= word_p0;
                cdet_p1 <= cdet_p0;
                rxv_p1  <= (state_nxt == LOCKED);
            end
        end
    end

`ifdef ALIGN_LOSS_CNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            loss_cnt <= 8'd0;
        end else if (lost_nxt && loss_cnt != 8'hFF) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign rx.Lock_Loss_Cnt = loss_cnt;
`endif

    assign rx.Data_out     = data_p1;
    assign rx.Comma_Det    = cdet_p1;
    assign rx.RX_Valid     = rxv_p1;
    assign rx.Align_Offset = off;
    assign rx.Lock_Lost    = lost_p1;

endmodule
